// File: rtl/hex_share_arb_if.sv
// Bus between the two requesters and the shared six-digit HEX bank.
interface hex_share_arb_if;
   logic        req_a;
   logic        req_b;
   logic [23:0] data_a;
   logic [23:0] data_b;
   logic [5:0]  blank_a;
   logic [5:0]  blank_b;
   logic        blink_a;
   logic        blink_b;
   logic        gnt_a;
   logic        gnt_b;
   logic [6:0]  HEX0;
   logic [6:0]  HEX1;
   logic [6:0]  HEX2;
   logic [6:0]  HEX3;
   logic [6:0]  HEX4;
   logic [6:0]  HEX5;

   modport master (
      output req_a, req_b, data_a, data_b, blank_a, blank_b, blink_a, blink_b,
      input  gnt_a, gnt_b, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );

   modport slave (
      input  req_a, req_b, data_a, data_b, blank_a, blank_b, blink_a, blink_b,
      output gnt_a, gnt_b, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );
endinterface

// File: rtl/hex_share_arb.sv
// Round-robin arbiter sharing one six-digit seven-segment bank between two requesters.
// Optional whole-bank blinking is compiled in with the HEX_BLINK_EN macro.
module hex_share_arb #(
   parameter int unsigned SLICE      = 8,
   parameter int unsigned BLINK_HALF = 4
) (
   input logic            clk,
   input logic            reset_n,
   hex_share_arb_if.slave bus
);

   localparam int unsigned CW = $clog2(SLICE);
   localparam logic [CW-1:0] CNT_MAX = CW'(SLICE - 1);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t        state;
   state_t        state_nxt;
   state_t        other;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          last_b;
   logic          last_b_nxt;
   logic          own_req;
   logic          oth_req;
   logic          gnt_a;
   logic          gnt_b;
   logic [23:0]   digits;
   logic [5:0]    mask;
   logic          blank_all;
   logic [6:0]    hex [6];

   // Arbitration state register; grants are derived from the next state so they stay registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         last_b <= 1'b1;
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         last_b <= last_b_nxt;
         gnt_a  <= (state_nxt == OWN_A);
         gnt_b  <= (state_nxt == OWN_B);
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      last_b_nxt = last_b;
      own_req    = (state == OWN_B) ? bus.req_b : bus.req_a;
      oth_req    = (state == OWN_B) ? bus.req_a : bus.req_b;
      other      = (state == OWN_B) ? OWN_A : OWN_B;
      case (state)
         IDLE: begin
            if (bus.req_a && bus.req_b) state_nxt = last_b ? OWN_A : OWN_B;
            else if (bus.req_a)         state_nxt = OWN_A;
            else if (bus.req_b)         state_nxt = OWN_B;
         end
         OWN_A, OWN_B: begin
            // Counter saturates at CNT_MAX; preemption only fires once the other side asks.
            if (!own_req)            state_nxt = oth_req ? other : IDLE;
            else if (cnt == CNT_MAX) begin
               if (oth_req) state_nxt = other;
            end else                 cnt_nxt = cnt + CW'(1);
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         cnt_nxt = '0;
         if (state_nxt == OWN_A)      last_b_nxt = 1'b0;
         else if (state_nxt == OWN_B) last_b_nxt = 1'b1;
      end
   end

   // Display registers capture the owner's payload one cycle after the grant.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         digits <= '0;
         mask   <= '1;
      end else begin
         case (state)
            OWN_A: begin
               digits <= bus.data_a;
               mask   <= bus.blank_a;
            end
            OWN_B: begin
               digits <= bus.data_b;
               mask   <= bus.blank_b;
            end
            default: mask <= '1;
         endcase
      end
   end

`ifdef HEX_BLINK_EN
   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic          blink_q;

   // Blink timebase restarts on every ownership change so each owner sees a full shown half first.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
         blink_q   <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
         case (state)
            OWN_A:   blink_q <= bus.blink_a;
            OWN_B:   blink_q <= bus.blink_b;
            default: blink_q <= 1'b0;
         endcase
      end
   end

   assign blank_all = blink_q & phase;
`else
   logic unused_blink;
   assign unused_blink = bus.blink_a ^ bus.blink_b;
   assign blank_all    = 1'b0;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         4'hF: seg7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         hex[i] = (mask[i] || blank_all) ? 7'b1111111 : seg7(digits[4*i +: 4]);
      end
   end

   assign bus.gnt_a = gnt_a;
   assign bus.gnt_b = gnt_b;
   assign bus.HEX0  = hex[0];
   assign bus.HEX1  = hex[1];
   assign bus.HEX2  = hex[2];
   assign bus.HEX3  = hex[3];
   assign bus.HEX4  = hex[4];
   assign bus.HEX5  = hex[5];

endmodule

// File: tb/tb_hex_share_arb.sv
// Self-checking bench for hex_share_arb (SLICE=4, BLINK_HALF=2); blink expectations follow HEX_BLINK_EN.
module tb_hex_share_arb;

   localparam logic [41:0] BLK = {42{1'b1}};
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   typedef struct {
      logic        rst_n;
      logic        ra;
      logic        rb;
      logic [23:0] da;
      logic [5:0]  ka;
      logic [23:0] db;
      logic [5:0]  kb;
      logic [1:0]  gnt;   // {gnt_a, gnt_b}
      logic [41:0] hex;   // {HEX5..HEX0}
   } vec_t;

   typedef struct {
      int          idx;
      logic [1:0]  gnt;
      logic [41:0] hex;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   vec_t vecs [$];
   exp_t sb [$];

   hex_share_arb_if bus ();

   hex_share_arb #(.SLICE(4), .BLINK_HALF(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [41:0] glyphs(input logic [23:0] d, input logic [5:0] k);
      logic [41:0] r;
      for (int i = 0; i < 6; i++) r[7*i +: 7] = k[i] ? 7'b1111111 : GLYPH[d[4*i +: 4]];
      return r;
   endfunction

   function automatic logic [41:0] hex_now();
      return {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
   endfunction

   task automatic add(input logic rst_n, input logic ra, input logic rb,
                      input logic [23:0] da, input logic [5:0] ka,
                      input logic [23:0] db, input logic [5:0] kb,
                      input logic [1:0] gnt, input logic [41:0] hex);
      vec_t v;
      v.rst_n = rst_n; v.ra = ra; v.rb = rb; v.da = da; v.ka = ka;
      v.db = db; v.kb = kb; v.gnt = gnt; v.hex = hex;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst_n, input logic ra, input logic rb,
                        input logic [23:0] da, input logic [5:0] ka,
                        input logic [23:0] db, input logic [5:0] kb, input logic bl_a);
      reset_n     = rst_n;
      bus.req_a   = ra;
      bus.req_b   = rb;
      bus.data_a  = da;
      bus.blank_a = ka;
      bus.data_b  = db;
      bus.blank_b = kb;
      bus.blink_a = bl_a;
      bus.blink_b = 1'b0;
   endtask

   initial begin
      exp_t e;
      logic [41:0] shown;
      logic [41:0] want;
      n_checks = 0;
      n_fail   = 0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);

      // Expected values are the state after the clock edge that follows each vector.
      add(0, 0, 0, 24'h0,      6'h00, 24'h0,      6'h00, 2'b00, BLK);
      add(1, 1, 0, 24'h012345, 6'h00, 24'h0,      6'h00, 2'b10, BLK);
      add(1, 1, 0, 24'h012345, 6'h00, 24'h0,      6'h00, 2'b10,
          {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
      add(1, 1, 0, 24'h6789AB, 6'h00, 24'h0,      6'h00, 2'b10, glyphs(24'h6789AB, 6'h00));
      add(1, 1, 0, 24'hCDEF01, 6'h02, 24'h0,      6'h00, 2'b10, glyphs(24'hCDEF01, 6'h02));
      add(1, 0, 0, 24'hCDEF01, 6'h02, 24'h0,      6'h00, 2'b00, glyphs(24'hCDEF01, 6'h02));
      add(1, 0, 0, 24'hCDEF01, 6'h02, 24'h0,      6'h00, 2'b00, BLK);
      add(0, 0, 0, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b00, BLK);
      add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b10, BLK);
      for (int i = 0; i < 3; i++)
         add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b10, glyphs(24'h111111, 6'h00));
      add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b01, glyphs(24'h111111, 6'h00));
      for (int i = 0; i < 3; i++)
         add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b01, glyphs(24'h222222, 6'h00));
      add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b10, glyphs(24'h222222, 6'h00));
      for (int i = 0; i < 3; i++)
         add(1, 1, 1, 24'h111111, 6'h00, 24'h222222, 6'h00, 2'b10, glyphs(24'h111111, 6'h00));
      add(1, 1, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b01, glyphs(24'h111111, 6'h00));
      add(1, 1, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b01,
          {7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110, 7'b1111111});
      add(0, 1, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b00, BLK);
      add(1, 1, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b10, BLK);
      add(1, 0, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b01, glyphs(24'h111111, 6'h00));
      add(1, 0, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b01, glyphs(24'hFFFFFF, 6'h01));
      add(1, 0, 0, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b00, glyphs(24'hFFFFFF, 6'h01));
      add(1, 0, 0, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b00, BLK);
      add(1, 0, 1, 24'h111111, 6'h00, 24'hFFFFFF, 6'h01, 2'b01, BLK);

      step();
      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].ka,
               vecs[i].db, vecs[i].kb, 1'b0);
         e.idx = i;
         e.gnt = vecs[i].gnt;
         e.hex = vecs[i].hex;
         sb.push_back(e);
         step();
         e = sb.pop_front();
         check($sformatf("vec%0d_gnt", e.idx), 42'({bus.gnt_a, bus.gnt_b}), 42'(e.gnt));
         check($sformatf("vec%0d_hex", e.idx), hex_now(), e.hex);
      end

      // Lone owner holds past the slice; a saturated counter then yields on the first contested edge.
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      step();
      drive(1'b1, 1'b1, 1'b0, 24'h012345, 6'h00, 24'h222222, 6'h00, 1'b0);
      step();
      check("hold_grant", 42'({bus.gnt_a, bus.gnt_b}), 42'(2'b10));
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("hold_c%0d", i), 42'({bus.gnt_a, bus.gnt_b}), 42'(2'b10));
      end
      drive(1'b1, 1'b1, 1'b1, 24'h012345, 6'h00, 24'h222222, 6'h00, 1'b0);
      step();
      check("saturated_preempt", 42'({bus.gnt_a, bus.gnt_b}), 42'(2'b01));

      // Blink request from owner A.
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      step();
      drive(1'b1, 1'b1, 1'b0, 24'h012345, 6'h00, 24'h0, 6'h00, 1'b1);
      step();
      check("blink_grant_hex", hex_now(), BLK);
      shown = glyphs(24'h012345, 6'h00);
      for (int k = 2; k < 10; k++) begin
         step();
`ifdef HEX_BLINK_EN
         want = (((k - 1) / 2) % 2 == 1) ? BLK : shown;
`else
         want = shown;
`endif
         check($sformatf("blink_e%0d", k), hex_now(), want);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_share_arb.md
HEX_SHARE_ARB -- requirements
Module: hex_share_arb

Interface
REQ-001 Parameter SLICE, default 8: maximum cycles an owner keeps the display while the other requester waits (SLICE >= 2).
REQ-002 Parameter BLINK_HALF, default 4: blink half-period in cycles (BLINK_HALF >= 1).
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1: synchronous, active-low reset.
REQ-005 Port req_a / req_b  input  1 each: requester A / B wants the six-digit HEX bank.
REQ-006 Port data_a / data_b  input  24 each: six hex nibbles; [3:0] goes to HEX0 and [23:20] goes to HEX5.
REQ-007 Port blank_a / blank_b  input  6 each: per-digit blank mask; bit i blanks HEXi.
REQ-008 Port blink_a / blink_b  input  1 each: request to blink the whole bank (honoured only under HEX_BLINK_EN).
REQ-009 Port gnt_a / gnt_b  output  1 each: registered grant, one-hot or both zero.
REQ-010 Port HEX0..HEX5  output  7 each: active-low segments, bit order 6543210 (g..a).

Function
REQ-011 The block SHALL implement three states: IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A and gnt_b=1 only in OWN_B.
REQ-012 In IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the requester not served last (last_served resets to B, so A wins first); none -> stay.
REQ-013 In OWN_X with req_X=0: go to OWN_other if req_other=1, else go to IDLE; the transition occurs on the next edge.
REQ-014 In OWN_X with req_X=1 and req_other=1: slice counter increments each cycle; at count SLICE-1, switch to OWN_other on the next edge (round-robin preemption).
REQ-015 In OWN_X with req_other=0: the owner holds indefinitely; the slice counter saturates at SLICE-1 and does not preempt.
REQ-016 The slice counter SHALL clear to 0 on every state change; its width is $clog2(SLICE).
REQ-017 last_served SHALL update to X on each entry into OWN_X.
REQ-018 Display registers (24-bit digits, 6-bit mask) SHALL load the current owner's data and blank each cycle in OWN_A/OWN_B, i.e. the data visible on the granted cycle plus 1.
REQ-019 In IDLE the mask register SHALL load 6'b111111.
REQ-020 HEXi SHALL equal 7'b1111111 when mask[i]=1, else the standard hex glyph of nibble i: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 HEX outputs SHALL be combinational from the display registers only, never directly from inputs.
REQ-022 The grant path SHALL have no combinational dependency on req inputs; gnt is registered.

Reset
REQ-023 When reset_n=0 at a clock edge, the block SHALL set state=IDLE, gnt_a=gnt_b=0, slice counter=0, last_served=B, digits=0, mask=6'b111111, and blink phase/counter=0, so all HEX outputs read 7'b1111111 the cycle after.
REQ-024 Reset asserted mid-ownership SHALL override every transition; requests present at release are arbitrated per REQ-012.

Configuration
REQ-025 Macro HEX_BLINK_EN defined: a blink counter counts 0..BLINK_HALF-1 and toggles a phase bit on wrap.
REQ-026 Under HEX_BLINK_EN, the counter and phase SHALL clear on every state change.
REQ-027 Under HEX_BLINK_EN, while the owner's blink input is 1 and phase=1, all HEX outputs SHALL read 7'b1111111.
REQ-028 Macro HEX_BLINK_EN undefined: no blink logic; the blink inputs are present but ignored.

Verification (SLICE=4, BLINK_HALF=2)
REQ-029 Reset, then req_a=1 with data_a=24'h012345, blank_a=0 -> gnt_a=1 next cycle; one cycle later HEX5..HEX0 = 1000000,1111001,0100100,0110000,0011001,0010010.
REQ-030 req_a and req_b asserted together from IDLE after reset -> A granted; both held -> gnt toggles A,B,A every 4 cycles.
REQ-031 OWN_A with req_b=0 for 20 cycles -> gnt_a stays 1; drop req_a -> IDLE and all HEX 7'b1111111 two cycles later.
REQ-032 blank_b=6'b000001 with data_b=24'hFFFFFF while owning -> HEX0=1111111 and HEX1..HEX5=0001110.
REQ-033 Assert reset_n=0 during OWN_B -> gnt_b=0 and all HEX blank next cycle; release with req_a=req_b=1 -> A granted.
REQ-034 With HEX_BLINK_EN and blink_a=1 owning -> HEX outputs alternate shown/blank every 2 cycles; without the macro -> steady display.
